// File: rtl/csr_pkg.sv
// csr_pkg
// Shared definitions for the CSR access controller slice: operation
// encodings, controller state encoding, the read-only address field value
// and a small address-classification helper.
package csr_pkg;

  typedef logic [1:0] csrOp_t;

  localparam csrOp_t CSR_OP_RESERVED = 2'b00;
  localparam csrOp_t CSR_OP_RW       = 2'b01;
  localparam csrOp_t CSR_OP_RS       = 2'b10;
  localparam csrOp_t CSR_OP_RC       = 2'b11;

  localparam logic [1:0] STATE_IDLE    = 2'b00;
  localparam logic [1:0] STATE_READ    = 2'b01;
  localparam logic [1:0] STATE_WRITE   = 2'b10;
  localparam logic [1:0] STATE_RESPOND = 2'b11;

  // Address bits [11:10] equal to this value mark a read-only CSR.
  localparam logic [1:0] CSR_READ_ONLY_FIELD = 2'b11;

  function automatic logic isReadOnlyAddress(input logic [11:0] address);
    return address[11:10] == CSR_READ_ONLY_FIELD;
  endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// csr_rmw_alu
// Combinational read-modify-write datapath: produces the value to write back
// to a CSR from the operation, the value read in the READ phase and the
// operand from the instruction.
// Ports:
//   op        - operation (RW / RS / RC; reserved passes oldValue through)
//   oldValue  - CSR contents sampled during READ
//   writeData - rs1 value or zero-extended immediate
//   newValue  - value to drive onto the CSR write bus
module csr_rmw_alu
  import csr_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] oldValue,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] newValue
);

  always_comb begin
    newValue = oldValue;
    case (op)
      CSR_OP_RW: newValue = writeData;
      CSR_OP_RS: newValue = oldValue | writeData;
      CSR_OP_RC: newValue = oldValue & ~writeData;
      default:   newValue = oldValue;
    endcase
  end

endmodule

// File: rtl/csr_access_controller.sv
// csr_access_controller
// Sequences one CSR instruction from the execute stage onto the shared CSR
// bus as read, optional write, then response carrying the old value.
// Flags unimplemented CSRs, reserved ops and writes to read-only CSRs.
//
// Optional feature (macro CSR_PRIV_CHECK_EN): adds input currentPrivilege;
// an access whose address bits [9:8] exceed it is flagged at acceptance,
// still performs the READ phase, never writes and returns 0.
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   reqValid/reqReady     - request handshake (ready only in IDLE)
//   reqAddress/reqOp      - target CSR and operation
//   reqWriteData          - operand; reqWriteSuppress marks x0/uimm==0
//   respValid/respReady   - response handshake
//   respReadData          - old CSR value (0 on error); respError - illegal
//   csrRead*              - read strobe/address and OR-combined bus returns
//   csrRequestOutput      - OR of all register blocks' hit lines
//   csrWrite*             - write strobe, address and data
//
// state   | meaning
// IDLE    | waiting for a request; reqReady high
// READ    | read strobe on bus, sample old value and hit
// WRITE   | write strobe with the modified value
// RESPOND | result presented until respReady
module csr_access_controller
  import csr_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef CSR_PRIV_CHECK_EN
  input  logic [1:0]               currentPrivilege,
`endif
  input  logic                     reqValid,
  output logic                     reqReady,
  input  logic [ADDRESS_WIDTH-1:0] reqAddress,
  input  logic [1:0]               reqOp,
  input  logic [DATA_WIDTH-1:0]    reqWriteData,
  input  logic                     reqWriteSuppress,
  output logic                     respValid,
  input  logic                     respReady,
  output logic [DATA_WIDTH-1:0]    respReadData,
  output logic                     respError,
  output logic                     csrReadEnable,
  output logic [ADDRESS_WIDTH-1:0] csrReadAddress,
  input  logic [DATA_WIDTH-1:0]    csrReadData,
  input  logic                     csrRequestOutput,
  output logic                     csrWriteEnable,
  output logic [ADDRESS_WIDTH-1:0] csrWriteAddress,
  output logic [DATA_WIDTH-1:0]    csrWriteData
);

  logic [1:0]               state;
  logic [ADDRESS_WIDTH-1:0] addressReg;
  logic [1:0]               opReg;
  logic [DATA_WIDTH-1:0]    dataReg;
  logic                     suppressReg;
  logic [DATA_WIDTH-1:0]    oldValueReg;
  logic                     errorReg;
  logic                     privErrorReg;
  logic                     privErrorNext;

  logic                     doWrite;
  logic                     readError;
  logic [DATA_WIDTH-1:0]    newValue;

`ifdef CSR_PRIV_CHECK_EN
  assign privErrorNext = reqAddress[9:8] > currentPrivilege;
`else
  assign privErrorNext = 1'b0;
`endif

  // RS/RC with x0/uimm==0 are pure reads; RW always writes.
  assign doWrite   = (opReg == CSR_OP_RW) || !suppressReg;
  assign readError = !csrRequestOutput || (opReg == CSR_OP_RESERVED) ||
                     (doWrite && isReadOnlyAddress(addressReg)) || privErrorReg;

  // oldValueReg is already the sampled read value once WRITE is reached.
  csr_rmw_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) uRmwAlu (
    .op       (opReg),
    .oldValue (oldValueReg),
    .writeData(dataReg),
    .newValue (newValue)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= STATE_IDLE;
      addressReg   <= '0;
      opReg        <= CSR_OP_RESERVED;
      dataReg      <= '0;
      suppressReg  <= 1'b0;
      oldValueReg  <= '0;
      errorReg     <= 1'b0;
      privErrorReg <= 1'b0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (reqValid) begin
            addressReg   <= reqAddress;
            opReg        <= reqOp;
            dataReg      <= reqWriteData;
            suppressReg  <= reqWriteSuppress;
            privErrorReg <= privErrorNext;
            errorReg     <= 1'b0;
            state        <= STATE_READ;
          end
        end
        STATE_READ: begin
          // Zeroing the captured value on error makes respReadData 0 directly.
          oldValueReg <= readError ? '0 : csrReadData;
          errorReg    <= readError;
          state       <= (!readError && doWrite) ? STATE_WRITE : STATE_RESPOND;
        end
        STATE_WRITE: begin
          state <= STATE_RESPOND;
        end
        STATE_RESPOND: begin
          if (respReady) begin
            state <= STATE_IDLE;
          end
        end
        default: begin
          state <= STATE_IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from state so an asynchronous reset drops every
  // strobe and address in the same instant.
  assign reqReady        = (state == STATE_IDLE);
  assign respValid       = (state == STATE_RESPOND);
  assign respReadData    = respValid ? oldValueReg : '0;
  assign respError       = respValid && errorReg;
  assign csrReadEnable   = (state == STATE_READ);
  assign csrReadAddress  = csrReadEnable ? addressReg : '0;
  assign csrWriteEnable  = (state == STATE_WRITE);
  assign csrWriteAddress = csrWriteEnable ? addressReg : '0;
  assign csrWriteData    = csrWriteEnable ? newValue : '0;

endmodule

// File: doc/csr_access_controller.md
Name: csr_access_controller

Overview:
- Sequences one CSR instruction (CSRRW/CSRRS/CSRRC and immediate forms) from the core pipeline onto the shared CSR bus.
- Each CSR register block decodes its own address. All blocks drive an OR-combined readData and an OR-combined request/hit line back to this controller.
- Performs the read-modify-write in order: read phase, compute, write phase, respond with the old value. Flags accesses to unimplemented CSRs and writes to read-only CSRs.
- Sits between the core's execute stage and all CSR register instances.

Parameters:
- DATA_WIDTH, 32, CSR data width; the bus is fixed at 32 and the value must not be changed.
- ADDRESS_WIDTH, 12, CSR address width; fixed by the ISA.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- reqValid  input  1  core presents a CSR operation.
- reqReady  output  1  controller can accept; high only in IDLE.
- reqAddress  input  12  target CSR address.
- reqOp  input  2  operation: 01 RW, 10 RS (set bits), 11 RC (clear bits); 00 is reserved and raises an error.
- reqWriteData  input  32  rs1 value or zero-extended immediate.
- reqWriteSuppress  input  1  rs1/uimm field is x0/0; for RS/RC no write is performed.
- respValid  output  1  result available.
- respReady  input  1  core accepts the result.
- respReadData  output  32  old CSR value (rd result).
- respError  output  1  illegal-instruction indication.
- csrReadEnable  output  1  CSR bus read strobe.
- csrReadAddress  output  12  CSR bus read address.
- csrReadData  input  32  OR of all register blocks' readData.
- csrRequestOutput  input  1  OR of all register blocks' hit lines.
- csrWriteEnable  output  1  CSR bus write strobe.
- csrWriteAddress  output  12  CSR bus write address.
- csrWriteData  output  32  CSR bus write data.

Behaviour:
- Reset values: state IDLE; reqReady 1; respValid 0; respError 0; respReadData 0; csrReadEnable 0; csrWriteEnable 0; both CSR address outputs 0; csrWriteData 0.
- State IDLE:
  - On reqValid&&reqReady, latch address, op, data and suppress into registers, then go to READ.
- State READ (one cycle):
  - csrReadEnable=1 and csrReadAddress=latched address.
  - Sample csrReadData and csrRequestOutput at the end of the cycle into oldValue and hit.
  - Go to ERROR-check (see Transitions below).
- Write decision (evaluated at the end of READ):
  - doWrite = (op==RW) || !suppress.
  - newValue: RW gives data; RS gives old|data; RC gives old&~data.
- Transitions out of READ:
  - !hit, op==00, or (doWrite && address[11:10]==2'b11) sets error=1, skips WRITE and goes to RESPOND.
  - Otherwise, if doWrite, go to WRITE; else go to RESPOND.
- State WRITE (one cycle):
  - csrWriteEnable=1, csrWriteAddress=latched address, csrWriteData=newValue.
  - Then go to RESPOND.
- State RESPOND:
  - respValid=1, respReadData=oldValue (0 on error), respError=error.
  - Hold all three stable until respReady; on respValid&&respReady, go to IDLE.
- Latency: accept at cycle 0, READ at cycle 1, WRITE at cycle 2, respValid at cycle 3 (cycle 2 when the write is skipped). Back-to-back throughput is one op per 3–4 cycles.
- The controller never asserts csrReadEnable and csrWriteEnable in the same cycle. Read and write addresses are driven only during their own phase and are 0 otherwise.
- Reset asserted mid-operation: return to IDLE immediately and drop all strobes; a partially completed write is not retried.
- reqValid is ignored outside IDLE. Request inputs are not required to stay stable after acceptance.

Optional Feature:
- Macro: CSR_PRIV_CHECK_EN.
- With the macro defined:
  - Extra input currentPrivilege (2 bits).
  - An access with reqAddress[9:8] > currentPrivilege is an error. This check is evaluated at acceptance and latched.
  - READ is still sequenced, but no write occurs and respReadData=0.
- Without the macro: the port is absent and there is no privilege check.

Decomposition:
- Shared package csr_pkg holds:
  - op encodings CSR_OP_RW/RS/RC/RESERVED;
  - state encoding IDLE/READ/WRITE/RESPOND;
  - the read-only address field value 2'b11.
- One natural sub-module, csr_rmw_alu: combinational newValue from op, oldValue and data.

Test Plan:
- RW to an implemented CSR 0x340 holding 0x0000_00AA, data 0x1234_5678: read strobe at cycle 1, write of 0x1234_5678 at cycle 2, respReadData=0xAA with respError=0 at cycle 3.
- RS with old 0x0000_00F0 and data 0x0F: write 0x0000_00FF. RC with old 0xFF and data 0x0F: write 0xF0.
- RS with reqWriteSuppress=1 to read-only 0xF14: no write strobe, respValid at cycle 2 with hartid data and respError=0. The same with RW: respError=1 and no write strobe.
- Unimplemented address 0x7C0 (csrRequestOutput=0): respError=1, respReadData=0, no write strobe.
- Hold respReady=0 for 5 cycles: respValid and data stay stable, reqReady stays 0, and a second reqValid is not accepted until the handshake completes.
- Assert rst during WRITE: csrWriteEnable falls the same cycle (asynchronously), state returns to IDLE, and reqReady=1 after release.
